i2c_slave_regif: RTL and testbench

- I2C target (responder): the opposite end of the I2C controller that drives scl/sda from the APB/UART side.
- Decodes START/STOP, matches a 7-bit address and ACKs it.
- Bridges I2C byte transfers onto a simple single-cycle register-bank port, with a byte pointer that auto-increments.
- Instantiated next to the controller at FPGA top level. The open-drain pads are split into in/oe pins at top level.

---
 rtl/i2c_slave_regif_pkg.sv | 26 ++
 rtl/i2c_line_sync.sv | 49 ++++
 rtl/i2c_slave_regif.sv | 197 +++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_regif_pkg.sv
// Shared definitions for the I2C target register interface: state encodings,
// acknowledge levels and the default target address.
package i2c_slave_regif_pkg;

  localparam logic [6:0] DEF_SLV_ADDR = 7'h50;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_MACK      = 4'd8,
    ST_WAIT      = 4'd9
  } i2c_state_e;

  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] slv_addr);
    return (addr_byte[7:1] == slv_addr);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the scl/sda pads and flags scl edges plus START/STOP conditions.
// Shared between the I2C target and controller sides.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Synchronizer chains plus one-cycle delayed copies; idle bus level is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= {SYNC_STAGES{1'b1}};
      r_sda_sync <= {SYNC_STAGES{1'b1}};
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // scl must be high on both samples so a data change racing an scl edge is not a START/STOP.
  assign o_scl_rise  = w_scl & ~r_scl_d;
  assign o_scl_fall  = ~w_scl & r_scl_d;
  assign o_start_det = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop_det  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign o_sda_s     = w_sda;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target that matches a 7-bit address and bridges byte transfers onto a
// single-cycle register-bank port with an auto-incrementing byte pointer.
module i2c_slave_regif
  import i2c_slave_regif_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR    = DEF_SLV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       prst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       i2c_if
);

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda;
  logic       w_shift_en;
  logic       w_byte_done;

  i2c_state_e r_state;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic [3:0] r_bit_cnt;
  logic       r_rw;
  logic       r_matched;
  logic       r_re_d;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk       (pclk),
    .i_rst_n     (prst_n),
    .i_scl       (scl_in),
    .i_sda       (sda_in),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop),
    .o_sda_s     (w_sda)
  );

  assign w_shift_en  = w_scl_rise &&
                       ((r_state == ST_ADDR) || (r_state == ST_PTR) || (r_state == ST_WDATA));
  assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

  // Protocol FSM; START/STOP take priority over any bit-level activity.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'h00;
      r_tx      <= 8'h00;
      r_bit_cnt <= 4'd0;
      r_rw      <= 1'b0;
      r_matched <= 1'b0;
      r_re_d    <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      i2c_if    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      i2c_if <= 1'b0;
      r_re_d <= reg_re;
      if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
        r_matched <= 1'b0;
        r_re_d    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        i2c_if    <= r_matched;
        r_matched <= 1'b0;
        r_re_d    <= 1'b0;
      end else if (r_re_d) begin
        // Bank data is valid the cycle after reg_re: load it and present bit 7.
        r_tx      <= reg_rdata;
        sda_oe    <= ~reg_rdata[7];
        r_bit_cnt <= 4'd1;
      end else begin
        if (w_shift_en) begin
          r_shift   <= {r_shift[6:0], w_sda};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        case (r_state)
          ST_ADDR: begin
            if (w_byte_done) begin
              r_bit_cnt <= 4'd0;
              if (addr_match(r_shift, SLV_ADDR)) begin
                sda_oe    <= ~ACK;
                r_rw      <= r_shift[0];
                r_matched <= 1'b1;
                r_state   <= ST_ADDR_ACK;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              sda_oe    <= 1'b0;
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                reg_re  <= 1'b1;
                r_state <= ST_RDATA;
              end else begin
                r_state <= ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (w_byte_done) begin
              reg_addr  <= r_shift;
              sda_oe    <= ~ACK;
              r_bit_cnt <= 4'd0;
              r_state   <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: begin
            if (w_scl_fall) begin
              sda_oe    <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (w_byte_done) begin
              reg_wdata <= r_shift;
              reg_we    <= 1'b1;
              sda_oe    <= ~ACK;
              r_bit_cnt <= 4'd0;
              r_state   <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              sda_oe    <= 1'b0;
              reg_addr  <= reg_addr + 8'd1;
              r_bit_cnt <= 4'd0;
              r_state   <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                r_state <= ST_MACK;
              end else begin
                sda_oe    <= ~r_tx[6];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_MACK: begin
            if (w_scl_rise) begin
              if (w_sda == NACK) begin
                r_state <= ST_WAIT;
              end else begin
                reg_addr <= reg_addr + 8'd1;
              end
            end else if (w_scl_fall) begin
              reg_re  <= 1'b1;
              r_state <= ST_RDATA;
            end
          end
          ST_IDLE, ST_WAIT: begin
            r_state <= r_state;
          end
          default: begin
            sda_oe  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Self-checking bench: bit-banged I2C controller, register-bank model and a
// scoreboard of expected register strobes.
module tb_i2c_slave_regif;

  localparam int Q = 8;

  logic       pclk   = 1'b0;
  logic       prst_n = 1'b0;
  logic       scl_m  = 1'b1;
  logic       sda_m  = 1'b1;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       i2c_if;
  wire        sda_line = sda_m & ~sda_oe;

  int n_chk  = 0;
  int n_pass = 0;
  int if_cnt = 0;
  int exp_if = 0;
  int viol   = 0;
  bit oe_seen = 1'b0;
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;
  logic [15:0] q_we[$];
  logic [7:0]  q_re[$];
  logic [15:0] exp_we;
  logic [7:0]  exp_re;

  always #5 pclk = ~pclk;

  i2c_slave_regif #(
    .SLV_ADDR    (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .i2c_if    (i2c_if)
  );

  // Register bank returns address+1, valid the cycle after reg_re.
  always @(posedge pclk) begin
    if (reg_re) reg_rdata <= reg_addr + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe monitor: pops the scoreboard on every reg_we / reg_re.
  always @(negedge pclk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (i2c_if) if_cnt++;
    if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re)) viol++;
    if (reg_we) begin
      if (q_we.size() == 0) chk("we_unexpected", q_we.size(), 1);
      else begin
        exp_we = q_we.pop_front();
        chk("we_addr_data", {reg_addr, reg_wdata}, exp_we);
      end
    end
    if (reg_re) begin
      if (q_re.size() == 0) chk("re_unexpected", q_re.size(), 1);
      else begin
        exp_re = q_re.pop_front();
        chk("re_addr", reg_addr, exp_re);
      end
    end
    prev_we = reg_we;
    prev_re = reg_re;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clk_wait(Q);
    scl_m = 1'b1; clk_wait(Q);
    sda_m = 1'b0; clk_wait(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    clk_wait(Q); sda_m = 1'b0;
    clk_wait(Q); scl_m = 1'b1;
    clk_wait(Q); sda_m = 1'b1;
    clk_wait(Q);
  endtask

  task automatic send_bit(input logic b, output logic s);
    clk_wait(Q); sda_m = b;
    clk_wait(Q); scl_m = 1'b1;
    clk_wait(Q); s = sda_line;
    clk_wait(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
    send_bit(mack, s);
  endtask

  task automatic end_txn(input string tag, input int inc);
    i2c_stop();
    clk_wait(8);
    exp_if += inc;
    chk({tag, "_i2c_if"}, if_cnt, exp_if);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;

    clk_wait(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_strobes", {reg_we, reg_re}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i2c_if", i2c_if, 0);
    prst_n = 1'b1;
    clk_wait(5);

    // Write two bytes from pointer 0x10
    q_we.push_back({8'h10, 8'h5A});
    q_we.push_back({8'h11, 8'hC3});
    i2c_start();
    clk_wait(4);
    chk("wr_busy_after_start", busy, 1);
    send_byte(8'hA0, ack); chk("wr_ack_addr", ack, 0);
    send_byte(8'h10, ack); chk("wr_ack_ptr", ack, 0);
    send_byte(8'h5A, ack); chk("wr_ack_d0", ack, 0);
    send_byte(8'hC3, ack); chk("wr_ack_d1", ack, 0);
    end_txn("wr", 1);
    chk("wr_ptr_after", reg_addr, 8'h12);

    // Random read of three bytes from 0x20
    q_re.push_back(8'h20);
    q_re.push_back(8'h21);
    q_re.push_back(8'h22);
    i2c_start();
    send_byte(8'hA0, ack); chk("rd_ack_addr_w", ack, 0);
    send_byte(8'h20, ack); chk("rd_ack_ptr", ack, 0);
    i2c_start();
    send_byte(8'hA1, ack); chk("rd_ack_addr_r", ack, 0);
    recv_byte(1'b0, d); chk("rd_byte0", d, 8'h21);
    recv_byte(1'b0, d); chk("rd_byte1", d, 8'h22);
    recv_byte(1'b1, d); chk("rd_byte2", d, 8'h23);
    clk_wait(Q);
    chk("rd_released_after_nack", sda_oe, 0);
    end_txn("rd", 1);
    chk("rd_ptr_after", reg_addr, 8'h22);

    // Address mismatch: no ACK, no strobes, no interrupt
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hB0, ack); chk("mm_nack_addr", ack, 1);
    send_byte(8'h00, ack); chk("mm_nack_data", ack, 1);
    end_txn("mm", 0);
    chk("mm_oe_never", oe_seen, 0);

    // Pointer wrap-around
    q_we.push_back({8'hFF, 8'h11});
    q_we.push_back({8'h00, 8'h22});
    i2c_start();
    send_byte(8'hA0, ack); chk("wrap_ack_addr", ack, 0);
    send_byte(8'hFF, ack); chk("wrap_ack_ptr", ack, 0);
    send_byte(8'h11, ack); chk("wrap_ack_d0", ack, 0);
    send_byte(8'h22, ack); chk("wrap_ack_d1", ack, 0);
    end_txn("wrap", 1);
    chk("wrap_ptr_after", reg_addr, 8'h01);

    // Reset while ACKing the address
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'(8'hA0 >> i), s);
    for (int i = 0; i < 40 && !sda_oe; i++) @(posedge pclk);
    chk("rst_mid_oe_before", sda_oe, 1);
    #2;
    prst_n = 1'b0;
    #1;
    chk("rst_mid_oe_async", sda_oe, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    clk_wait(4);
    prst_n = 1'b1;
    clk_wait(4);
    i2c_start();
    send_byte(8'hA0, ack); chk("rst_mid_ack_after", ack, 0);
    end_txn("rst_mid", 1);

    // STOP in the middle of a pointer byte
    i2c_start();
    send_byte(8'hA0, ack); chk("sm_setup_ack_addr", ack, 0);
    send_byte(8'h33, ack); chk("sm_setup_ack_ptr", ack, 0);
    end_txn("sm_setup", 1);
    i2c_start();
    send_byte(8'hA0, ack); chk("sm_ack_addr", ack, 0);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    end_txn("sm", 1);
    chk("sm_ptr_unchanged", reg_addr, 8'h33);

    clk_wait(4);
    chk("we_queue_drained", q_we.size(), 0);
    chk("re_queue_drained", q_re.size(), 0);
    chk("strobe_excl_width", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
